// File: rtl/writeback_queue.sv
// Writeback queue: in-order buffer in front of the register file's single
// write port. Requests to register 0 are swallowed, the rest drain one per
// cycle whenever drain_en allows.
// Optional feature macro WBQ_BYPASS_EN: when defined, the two lookup ports
// forward the youngest pending value for a register; when undefined the
// lookup outputs are tied to zero.
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_waddr,
  input  logic [DATA_W-1:0]        in_wdata,
  input  logic                     drain_en,
  output logic                     wren,
  output logic [ADDR_W-1:0]        waddr,
  output logic [DATA_W-1:0]        wdata,
  input  logic [ADDR_W-1:0]        lk_addr0,
  input  logic [ADDR_W-1:0]        lk_addr1,
  output logic                     lk_hit0,
  output logic [DATA_W-1:0]        lk_data0,
  output logic                     lk_hit1,
  output logic [DATA_W-1:0]        lk_data1,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              do_push;
  logic              do_pop;

  // Status is derived only from the registered occupancy count.
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign in_ready = !full;

  // Writes to register 0 are accepted but never enqueued.
  assign do_push = in_valid && in_ready && (in_waddr != '0);
  assign do_pop  = wren;

  // The head entry is presented on the write port; zeros while empty.
  assign wren  = !empty && drain_en;
  assign waddr = empty ? '0 : mem_addr[head];
  assign wdata = empty ? '0 : mem_data[head];

  // Pointer, occupancy and per-entry valid bookkeeping; reset drops every pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (do_pop) begin
        head        <= head + 1'b1;
        valid[head] <= 1'b0;
      end
      if (do_push) begin
        tail        <= tail + 1'b1;
        valid[tail] <= 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage; not cleared by reset since valid bits gate its use.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_addr[tail] <= in_waddr;
      mem_data[tail] <= in_wdata;
    end
  end

`ifdef WBQ_BYPASS_EN
  logic [PTR_W-1:0] idx;

  // Scan oldest to youngest so the last match seen is the youngest pending value.
  always_comb begin
    idx      = '0;
    lk_hit0  = 1'b0;
    lk_data0 = '0;
    lk_hit1  = 1'b0;
    lk_data1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid[idx] && (lk_addr0 != '0) && (mem_addr[idx] == lk_addr0)) begin
        lk_hit0  = 1'b1;
        lk_data0 = mem_data[idx];
      end
      if (valid[idx] && (lk_addr1 != '0) && (mem_addr[idx] == lk_addr1)) begin
        lk_hit1  = 1'b1;
        lk_data1 = mem_data[idx];
      end
    end
  end
`else
  logic unused_lookup;

  assign lk_hit0       = 1'b0;
  assign lk_data0      = '0;
  assign lk_hit1       = 1'b0;
  assign lk_data1      = '0;
  assign unused_lookup = ^{valid, lk_addr0, lk_addr1};
`endif

endmodule
